// File: rtl/disp_pkg.sv
// Shared display definitions: owner state encoding, digit count, blank codes.
package disp_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_OWN0 = 2'd1;
   localparam logic [1:0] S_OWN1 = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = S_IDLE,
      ST_OWN0 = S_OWN0,
      ST_OWN1 = S_OWN1
   } own_state_e;

   localparam int        NUM_DIGITS = 6;
   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [5:0] SEL_NONE  = 6'h3F;

   // What one scan slot shows: latched at slot start, held for the whole slot
   typedef struct packed {
      logic       show;
      logic [3:0] nib;
   } slot_t;

   // Active-low one-hot digit enable for a digit index
   function automatic logic [5:0] digit_sel(input logic [2:0] idx);
      return ~(6'b000001 << idx);
   endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module seg7_hex_decode (
   input  logic [3:0] hex_i,
   output logic [6:0] seg_o
);

   // Pure lookup; shared with other display blocks
   always_comb begin
      seg_o = 7'h7F;
      unique case (hex_i)
         4'h0: seg_o = 7'h40;
         4'h1: seg_o = 7'h79;
         4'h2: seg_o = 7'h24;
         4'h3: seg_o = 7'h30;
         4'h4: seg_o = 7'h19;
         4'h5: seg_o = 7'h12;
         4'h6: seg_o = 7'h02;
         4'h7: seg_o = 7'h78;
         4'h8: seg_o = 7'h00;
         4'h9: seg_o = 7'h10;
         4'hA: seg_o = 7'h08;
         4'hB: seg_o = 7'h03;
         4'hC: seg_o = 7'h46;
         4'hD: seg_o = 7'h21;
         4'hE: seg_o = 7'h06;
         4'hF: seg_o = 7'h0E;
         default: seg_o = 7'h7F;
      endcase
   end

endmodule

// File: rtl/disp_share_sched.sv
// Shares the 6-digit multiplexed display between a normal source (0) and a
// priority alert source (1): req/gnt arbitration with minimum hold time,
// digit scan with a blanking interval at the start of every slot, and
// optional blinking for the alert source.
module disp_share_sched
   import disp_pkg::*;
#(
   parameter int DIVCLK_CNTMAX_1ms = 49999,
   parameter int BLANK_CYCLES      = 500,
   parameter int HOLD_MS           = 1000,
   parameter int BLINK_MS          = 500
) (
   input  logic        clk_50M,
   input  logic        rst,
   input  logic        req0,
   input  logic [23:0] data0,
   input  logic        req1,
   input  logic [23:0] data1,
   input  logic        blink1,
   output logic        gnt0,
   output logic        gnt1,
   output logic [5:0]  seg_sel,
   output logic [7:0]  seg_led
);

   localparam int DIV_W   = (DIVCLK_CNTMAX_1ms > 0) ? $clog2(DIVCLK_CNTMAX_1ms + 1) : 1;
   localparam int HOLD_W  = (HOLD_MS > 0) ? $clog2(HOLD_MS + 1) : 1;
   localparam int BLINK_W = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

   localparam logic [DIV_W-1:0]   DIV_MAX   = DIV_W'(DIVCLK_CNTMAX_1ms);
   localparam logic [DIV_W-1:0]   BLANK_END = DIV_W'(BLANK_CYCLES);
   localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(HOLD_MS);
   localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'((BLINK_MS > 0) ? BLINK_MS - 1 : 0);
   localparam logic [2:0]         IDX_LAST  = 3'(NUM_DIGITS - 1);

   logic [DIV_W-1:0]   div_q, div_d;
   logic               tick;
   logic [2:0]         idx_q, idx_d;
   logic [BLINK_W-1:0] bcnt_q, bcnt_d;
   logic               phase_q, phase_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;
   logic               hold_done;
   own_state_e         state_q, state_d;
   logic               gnt0_q, gnt1_q;
   slot_t              slot_q, slot_d;
   logic [5:0]         sel_q, sel_d;
   logic [7:0]         led_q, led_d;
   logic [6:0]         dec_seg;

   // Digit view of each requester's data bus
   logic [NUM_DIGITS-1:0][3:0] d0v, d1v;
   assign d0v = data0;
   assign d1v = data1;

   assign hold_done = (hold_q == HOLD_MAX);

   // Timebase: 1 ms tick, digit index and blink phase all advance on the tick
   always_comb begin
      tick    = (div_q == DIV_MAX);
      div_d   = tick ? '0 : div_q + 1'b1;
      idx_d   = idx_q;
      bcnt_d  = bcnt_q;
      phase_d = phase_q;
      if (tick) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
         if (bcnt_q == BLINK_MAX) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
         end else begin
            bcnt_d = bcnt_q + 1'b1;
         end
      end
   end

   // Ownership arbitration; requester 1 wins ties and may pre-empt once hold is done
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req1)      state_d = ST_OWN1;
            else if (req0) state_d = ST_OWN0;
         end
         ST_OWN0: begin
            if (!req0)                state_d = req1 ? ST_OWN1 : ST_IDLE;
            else if (req1 && hold_done) state_d = ST_OWN1;
         end
         ST_OWN1: begin
            if (!req1) state_d = req0 ? ST_OWN0 : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Hold timer restarts on every state entry and saturates at the hold limit
   always_comb begin
      hold_d = hold_q;
      if (state_d != state_q)       hold_d = '0;
      else if (tick && !hold_done)  hold_d = hold_q + 1'b1;
   end

   // Slot latch: owner, nibble and blink decision are frozen at slot start so an
   // ownership change mid-slot never tears the digit being shown
   always_comb begin
      slot_d = slot_q;
      if (tick) begin
         unique case (state_d)
            ST_OWN0: begin
               slot_d.show = 1'b1;
               slot_d.nib  = d0v[idx_d];
            end
            ST_OWN1: begin
               slot_d.show = !(blink1 && phase_d);
               slot_d.nib  = d1v[idx_d];
            end
            default: begin
               slot_d.show = 1'b0;
               slot_d.nib  = '0;
            end
         endcase
      end
   end

   seg7_hex_decode u_dec (
      .hex_i (slot_d.nib),
      .seg_o (dec_seg)
   );

   // Pin values computed from next-state so the registered pins line up with the counters
   always_comb begin
      sel_d = SEL_NONE;
      led_d = SEG_BLANK;
      if (slot_d.show && (state_d != ST_IDLE) && (div_d >= BLANK_END)) begin
         sel_d = digit_sel(idx_d);
         led_d = {1'b1, dec_seg};
      end
   end

   // Ownership state, hold timer and grants (grants trail the state by one clock)
   always_ff @(posedge clk_50M) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         hold_q  <= '0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         gnt0_q  <= (state_q == ST_OWN0);
         gnt1_q  <= (state_q == ST_OWN1);
      end
   end

   // Scan timebase, slot latch and registered display pins
   always_ff @(posedge clk_50M) begin
      if (!rst) begin
         div_q   <= '0;
         idx_q   <= '0;
         bcnt_q  <= '0;
         phase_q <= 1'b0;
         slot_q  <= '0;
         sel_q   <= SEL_NONE;
         led_q   <= SEG_BLANK;
      end else begin
         div_q   <= div_d;
         idx_q   <= idx_d;
         bcnt_q  <= bcnt_d;
         phase_q <= phase_d;
         slot_q  <= slot_d;
         sel_q   <= sel_d;
         led_q   <= led_d;
      end
   end

   assign gnt0    = gnt0_q;
   assign gnt1    = gnt1_q;
   assign seg_sel = sel_q;
   assign seg_led = led_q;

endmodule

// File: tb/tb_disp_share_sched.sv
// Bench for disp_share_sched with a 4-clock slot, 1 blank clock, 4-tick hold
// and 2-tick blink half-period. Display expectations are queued per slot when
// stimulus is applied and compared by a negedge scoreboard monitor.
module tb_disp_share_sched;

   localparam int DIV   = 3;
   localparam int SLOT  = DIV + 1;
   localparam int BLANK = 1;
   localparam int HOLD  = 4;
   localparam int BLINK = 2;

   logic        clk_50M = 1'b0;
   logic        rst;
   logic        req0, req1, blink1;
   logic [23:0] data0, data1;
   logic        gnt0, gnt1;
   logic [5:0]  seg_sel;
   logic [7:0]  seg_led;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;   // clocks since reset release; scan position follows from it

   typedef struct {
      int         t;
      logic [5:0] sel;
      logic [7:0] led;
      bit         vis;
   } slot_exp_t;

   slot_exp_t exp_q[$];

   logic [6:0] hex_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   disp_share_sched #(
      .DIVCLK_CNTMAX_1ms (DIV),
      .BLANK_CYCLES      (BLANK),
      .HOLD_MS           (HOLD),
      .BLINK_MS          (BLINK)
   ) dut (
      .clk_50M (clk_50M),
      .rst     (rst),
      .req0    (req0),
      .data0   (data0),
      .req1    (req1),
      .data1   (data1),
      .blink1  (blink1),
      .gnt0    (gnt0),
      .gnt1    (gnt1),
      .seg_sel (seg_sel),
      .seg_led (seg_led)
   );

   always #5 clk_50M = ~clk_50M;

   always @(posedge clk_50M) cyc <= rst ? cyc + 1 : 0;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   // Queue the expected appearance of slot t showing the given data word
   function automatic void push_slot(input int t, input logic [23:0] data, input bit vis);
      slot_exp_t   e;
      logic [23:0] d;
      int          idx;
      idx   = t % 6;
      d     = data >> (4 * idx);
      e.t   = t;
      e.sel = ~(6'b000001 << idx);
      e.led = {1'b1, hex_lut[d[3:0]]};
      e.vis = vis;
      exp_q.push_back(e);
   endfunction

   // Scoreboard: compare each clock of a queued slot, pop at slot end
   always @(negedge clk_50M) begin
      if (rst && exp_q.size() > 0) begin
         if (cyc / SLOT > exp_q[0].t) begin
            checks++;
            errors++;
            $display("FAIL scan slot %0d not observed (now slot %0d)", exp_q[0].t, cyc / SLOT);
            void'(exp_q.pop_front());
         end else if (cyc / SLOT == exp_q[0].t) begin
            checks++;
            if (((cyc % SLOT) >= BLANK && exp_q[0].vis) ?
                (seg_sel !== exp_q[0].sel || seg_led !== exp_q[0].led) :
                (seg_sel !== 6'h3F || seg_led !== 8'hFF)) begin
               errors++;
               $display("FAIL scan slot %0d clk %0d: seg_sel=%h seg_led=%h expected vis=%0d sel=%h led=%h",
                        exp_q[0].t, cyc % SLOT, seg_sel, seg_led, exp_q[0].vis, exp_q[0].sel, exp_q[0].led);
            end
            if (cyc % SLOT == SLOT - 1) void'(exp_q.pop_front());
         end
      end
   end

   task automatic align(input int m, input int v);
      while (cyc % m != v) @(negedge clk_50M);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         @(negedge clk_50M);
         n++;
      end
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard drain: %0d slots left, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; req0 = 1'b0; req1 = 1'b0; blink1 = 1'b0;
      data0 = '0; data1 = '0;
      repeat (4) begin
         @(negedge clk_50M);
         checks++;
         if (seg_sel !== 6'h3F || seg_led !== 8'hFF || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: sel=%h led=%h gnt=%b%b, expected 3f ff 00", seg_sel, seg_led, gnt1, gnt0);
         end
      end
      rst = 1'b1;
      repeat (26) begin
         @(negedge clk_50M);
         checks++;
         if (seg_sel !== 6'h3F || seg_led !== 8'hFF || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL idle_blank: sel=%h led=%h gnt=%b%b, expected 3f ff 00", seg_sel, seg_led, gnt1, gnt0);
         end
      end
   endtask

   task automatic test_req0();
      int k;
      align(24, 20);
      k = cyc;
      data0 = 24'h000017;
      req0  = 1'b1;
      @(negedge clk_50M);
      checks++;
      if (gnt0 !== 1'b0) begin
         errors++;
         $display("FAIL req0_gnt_lag: gnt0=%b, expected 0", gnt0);
      end
      @(negedge clk_50M);
      checks++;
      if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
         errors++;
         $display("FAIL req0_gnt: gnt0=%b gnt1=%b, expected 1 0", gnt0, gnt1);
      end
      for (int t = k / SLOT + 1; t <= k / SLOT + 12; t++) push_slot(t, data0, 1'b1);
      drain(80);
   endtask

   task automatic test_preempt();
      int k;
      req0 = 1'b0;
      repeat (2) @(negedge clk_50M);
      checks++;
      if (gnt0 !== 1'b0) begin
         errors++;
         $display("FAIL release: gnt0=%b, expected 0", gnt0);
      end
      align(24, 4);
      k = cyc;
      req0 = 1'b1;
      for (int i = 1; i <= 18; i++) begin
         @(negedge clk_50M);
         if (i == 4) begin
            data1 = 24'h000042;
            req1  = 1'b1;
            push_slot((k + 16) / SLOT, data0, 1'b1);
            for (int t = (k + 20) / SLOT; t < (k + 20) / SLOT + 6; t++) push_slot(t, data1, 1'b1);
         end
         checks++;
         if (gnt0 !== (i >= 2 && i <= 17) || gnt1 !== (i >= 18)) begin
            errors++;
            $display("FAIL preempt clk %0d: gnt0=%b gnt1=%b, expected %b %b",
                     i, gnt0, gnt1, (i >= 2 && i <= 17), (i >= 18));
         end
      end
      drain(60);
   endtask

   task automatic test_simultaneous();
      req0 = 1'b0;
      req1 = 1'b0;
      repeat (2) @(negedge clk_50M);
      checks++;
      if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
         errors++;
         $display("FAIL simul_idle: gnt0=%b gnt1=%b, expected 0 0", gnt0, gnt1);
      end
      req0 = 1'b1;
      req1 = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk_50M);
         checks++;
         if (gnt0 !== 1'b0 || gnt1 !== (i >= 2)) begin
            errors++;
            $display("FAIL simul_rise clk %0d: gnt0=%b gnt1=%b, expected 0 %b", i, gnt0, gnt1, (i >= 2));
         end
      end
      req1 = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk_50M);
         checks++;
         if (gnt1 !== (i == 1) || gnt0 !== (i >= 2)) begin
            errors++;
            $display("FAIL simul_handover clk %0d: gnt0=%b gnt1=%b, expected %b %b",
                     i, gnt0, gnt1, (i >= 2), (i == 1));
         end
      end
   endtask

   task automatic test_blink();
      int k;
      align(SLOT, 0);
      k = cyc;
      data1  = 24'h543210;
      blink1 = 1'b1;
      req0   = 1'b0;
      req1   = 1'b1;
      // slot t starts after t ticks; phase after t ticks is (t / BLINK) % 2
      for (int t = k / SLOT + 1; t <= k / SLOT + 16; t++) push_slot(t, data1, ((t / BLINK) % 2) == 0);
      drain(80);
      align(SLOT, 0);
      k = cyc;
      blink1 = 1'b0;
      for (int t = k / SLOT + 1; t <= k / SLOT + 6; t++) push_slot(t, data1, 1'b1);
      drain(40);
   endtask

   task automatic test_mid_reset();
      align(SLOT, 2);
      rst = 1'b0;
      @(negedge clk_50M);
      checks++;
      if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || seg_sel !== 6'h3F || seg_led !== 8'hFF) begin
         errors++;
         $display("FAIL mid_reset: gnt=%b%b sel=%h led=%h, expected 00 3f ff", gnt1, gnt0, seg_sel, seg_led);
      end
      rst = 1'b1;
      @(negedge clk_50M);
      @(negedge clk_50M);
      checks++;
      if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
         errors++;
         $display("FAIL regrant: gnt1=%b gnt0=%b, expected 1 0", gnt1, gnt0);
      end
      // digit index restarts at 0, so slot 1 is digit 1 and slot 6 wraps to digit 0
      for (int t = 1; t <= 6; t++) push_slot(t, data1, 1'b1);
      drain(40);
   endtask

   initial begin
      test_reset();
      test_req0();
      test_preempt();
      test_simultaneous();
      test_blink();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/disp_share_sched.md
Name: disp_share_sched

Overview:
- Scheduler that shares the 6-digit multiplexed seven-segment display between two requesters.
- Requester 0 is the normal counter/value source. Requester 1 is a high-priority alert/message source.
- The block arbitrates ownership with a req/gnt handshake and a minimum hold time.
- It also sequences the digit scan, inserting a blanking interval at the start of every digit slot to suppress ghosting.
- It sits between the counter logic and the seg_sel/seg_led pins, replacing the free-running scan in the display top.

Parameters:
- DIVCLK_CNTMAX_1ms, 49999, terminal count of the 1 ms tick divider; slot length is DIVCLK_CNTMAX_1ms+1 clocks.
- BLANK_CYCLES, 500, blanked clocks at the start of each slot. Must be < DIVCLK_CNTMAX_1ms+1.
- HOLD_MS, 1000, minimum ms the current owner keeps the display before it can be pre-empted.
- BLINK_MS, 500, blink half-period in ms.

Ports:
- clk_50M  in  1  system clock
- rst  in  1  synchronous reset, active-low
- req0  in  1  requester 0 wants the display
- data0  in  24  requester 0 digits, 6 x 4-bit; [3:0] is the rightmost digit
- req1  in  1  requester 1 (priority) wants the display
- data1  in  24  requester 1 digits, same layout as data0
- blink1  in  1  blink the display while requester 1 owns it
- gnt0  out  1  requester 0 owns the display
- gnt1  out  1  requester 1 owns the display
- seg_sel  out  6  digit enables, active-low, one-hot-zero
- seg_led  out  8  segments {dp,g,f,e,d,c,b,a}, active-low; dp always off (1)

Behaviour:
- Reset (rst=0 at a clk_50M edge):
  - state IDLE; gnt0=gnt1=0
  - seg_sel=6'h3F, seg_led=8'hFF
  - tick divider, digit index, hold counter and blink counter all cleared to 0
- Tick: the divider counts 0..DIVCLK_CNTMAX_1ms and emits a 1-clock tick at the terminal count.
- Ownership FSM (IDLE, OWN0, OWN1), evaluated every clock:
  - IDLE: req1 -> OWN1; else req0 -> OWN0; else stay.
  - OWN0:
    - !req0 -> OWN1 if req1, else IDLE (release is immediate).
    - req0 & req1 & hold_done -> OWN1 (pre-emption).
    - Otherwise stay.
  - OWN1:
    - !req1 -> OWN0 if req0, else IDLE.
    - Never pre-empted.
  - Simultaneous req0 and req1 rise in IDLE -> OWN1.
- Hold counter:
  - Cleared on every state entry; increments on each tick; saturates at HOLD_MS.
  - hold_done = (count == HOLD_MS).
  - HOLD_MS=0 means immediate pre-emption.
- Grants:
  - gnt0/gnt1 are registered, one-hot or zero.
  - They assert 1 clock after the state register enters OWNx and deassert 1 clock after it leaves.
  - Never both high, including in the transition cycle.
- Requester rule: hold req until done. A requester whose req drops loses its grant even if it re-raises req in the next cycle, and it then re-arbitrates.
- Scan:
  - Digit index 0..5 advances on each tick and wraps 5->0.
  - A slot is the clocks between ticks.
  - Slot clock counter < BLANK_CYCLES: seg_sel=6'h3F, seg_led=8'hFF.
  - Otherwise: seg_sel = ~(6'b1 << idx).
  - seg_led = decode of the owner's nibble idx, sampled from data0/1 at slot start and held for the whole slot.
- Decode: hex 0-F, active-low (0 -> 7'b1000000 on {g..a}, ... F -> 7'b0001110).
- IDLE: display fully blank; the scan keeps running.
- Blink:
  - The phase counter counts ticks 0..BLINK_MS-1 and toggles the phase at wrap.
  - It runs continuously, not restarted on grant.
  - In OWN1 with blink1=1 and phase=1, the whole slot is blanked.
  - blink1 is ignored in OWN0.
- Ownership change mid-slot: the current slot finishes with the latched nibble. The new owner's data appears from the next slot.
- Reset mid-operation returns everything to reset values on the same edge. No grant survives reset.
- Output timing: all outputs are registered, with no combinational path from inputs to outputs.

Decomposition:
- Package disp_pkg holds:
  - state encoding localparams (IDLE/OWN0/OWN1)
  - NUM_DIGITS=6
  - SEG_BLANK=8'hFF, SEL_NONE=6'h3F
- Sub-module seg7_hex_decode: 4-bit in, 7-bit active-low segment out, combinational, reused by other display blocks.
- Expected size ~200 RTL lines.

Test Plan (bench parameters: DIVCLK_CNTMAX_1ms=3, BLANK_CYCLES=1, HOLD_MS=4, BLINK_MS=2):
- Reset scan blanking: hold rst=0 for 4 clocks with req0=req1=0 -> seg_sel=3F and seg_led=FF throughout. After release, gnt0=gnt1=0 and the display stays blank for 24+ clocks.
- req0 single requester: req0=1, data0=24'h000017 -> gnt0=1 one clock after OWN0 entry. Slot idx0 shows seg_sel=3E, seg_led=F8 ('7') after the 1-clock blank. idx1 shows seg_sel=3D, seg_led=F9 ('1'). idx2..5 show C0. Index wraps after 6 ticks.
- Hold and pre-emption: in OWN0, raise req1 (data1=24'h000042) 1 tick after grant -> gnt0 stays 1 until hold_done at the 4th tick. Then gnt0=0 and gnt1=1 on consecutive edges, never both high. The next slot shows '2' (A4) on idx0.
- Simultaneous request: from IDLE raise req0 and req1 on the same edge -> gnt1 only. Dropping req1 -> gnt1=0, then gnt0=1 with no IDLE gap.
- Blink: OWN1 with blink1=1 -> display blanked for alternate 2-tick windows (8 clocks visible, 8 blank). blink1=0 -> continuously visible.
- Mid-operation reset: rst=0 while OWN1 mid-slot -> next edge gives gnt1=0, seg_sel=3F, seg_led=FF, idx=0. After release with req1 still high -> re-granted within 2 clocks.
